// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic feeder: FSM states, phase lengths
// and the lane-slice helper used to address packed lane vectors.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // Phase lengths for the default 4x4 array
    localparam int ARRAY_SIZE_DEF = 4;
    localparam int STREAM_LEN     = 2 * ARRAY_SIZE_DEF - 1;
    localparam int FLUSH_LEN      = ARRAY_SIZE_DEF;

    // Stream phase covers every diagonal of an n x n operand
    function automatic int stream_len(input int n);
        return 2 * n - 1;
    endfunction

    // Flush phase lets the last diagonal travel across the array
    function automatic int flush_len(input int n);
        return n;
    endfunction

    // Low bit index of lane `lane` in a packed vector of `width`-bit lanes
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed lane: at stream beat t it presents element (t - LANE) of its
// N-entry vector, or zero when that index falls outside 0..N-1.
module systolic_skew_lane
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 4,
    parameter int T_W        = 3,
    parameter int LANE       = 0
) (
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] i_vec,
    input  logic [T_W-1:0]                   i_t,
    output logic [DATA_WIDTH-1:0]            o_elem
);

    // Select the element whose index equals t - LANE; default is zero padding
    always_comb begin
        o_elem = '0;
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            if (int'(i_t) == k + LANE) begin
                o_elem = i_vec[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array feeder: loads A row-by-row and B column-by-column over a
// valid/ready handshake, streams both in diagonally skewed order, then
// flushes zeros so the array drains and pulses done.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_a_row,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_b_col,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_left,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_top,
    output logic                             out_first,
    output logic                             busy,
    output logic                             done
);

    localparam int N     = ARRAY_SIZE;
    localparam int W     = DATA_WIDTH;
    localparam int LW    = N * W;
    localparam int K_W   = (N > 1) ? $clog2(N) : 1;
    localparam int T_W   = $clog2(2 * N);
    localparam int S_LEN = stream_len(N);
    localparam int F_LEN = flush_len(N);

    localparam logic [K_W-1:0] K_LAST        = K_W'(N - 1);
    localparam logic [T_W-1:0] T_STREAM_LAST = T_W'(S_LEN - 1);
    localparam logic [T_W-1:0] T_FLUSH_LAST  = T_W'(F_LEN - 1);

    state_t          r_state;
    state_t          w_next;
    logic [K_W-1:0]  r_k;
    logic [T_W-1:0]  r_t;
    logic [LW-1:0]   r_a [N];   // r_a[i] = row i of A, lane c = A[i][c]
    logic [LW-1:0]   r_b [N];   // r_b[j] = column j of B, lane r = B[r][j]
    logic [LW-1:0]   w_left;
    logic [LW-1:0]   w_top;
    logic            w_hs;

    assign w_hs = in_valid && (r_state == ST_LOAD);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_LOAD;
        else       r_state <= w_next;
    end

    // Next-state: last load beat starts the stream, phase counters end each phase
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOAD:   if (w_hs && r_k == K_LAST)  w_next = ST_STREAM;
            ST_STREAM: if (r_t == T_STREAM_LAST)   w_next = ST_FLUSH;
            ST_FLUSH:  if (r_t == T_FLUSH_LAST)    w_next = ST_LOAD;
            default:                               w_next = ST_LOAD;
        endcase
    end

    // Beat counter k during LOAD, phase counter t during STREAM and FLUSH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k <= '0;
            r_t <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_t <= '0;
                    if (w_hs) r_k <= (r_k == K_LAST) ? '0 : r_k + K_W'(1);
                end
                ST_STREAM: r_t <= (r_t == T_STREAM_LAST) ? '0 : r_t + T_W'(1);
                ST_FLUSH: begin
                    r_k <= '0;
                    r_t <= (r_t == T_FLUSH_LAST) ? '0 : r_t + T_W'(1);
                end
                default: begin
                    r_k <= '0;
                    r_t <= '0;
                end
            endcase
        end
    end

    // Operand buffers hold data only; contents are masked outside STREAM
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_a[r_k] <= in_a_row;
            r_b[r_k] <= in_b_col;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        systolic_skew_lane #(
            .ARRAY_SIZE (N),
            .DATA_WIDTH (W),
            .T_W        (T_W),
            .LANE       (gi)
        ) u_left (
            .i_vec  (r_a[gi]),
            .i_t    (r_t),
            .o_elem (w_left[gi*W +: W])
        );

        systolic_skew_lane #(
            .ARRAY_SIZE (N),
            .DATA_WIDTH (W),
            .T_W        (T_W),
            .LANE       (gi)
        ) u_top (
            .i_vec  (r_b[gi]),
            .i_t    (r_t),
            .o_elem (w_top[gi*W +: W])
        );
    end

    // Outputs decode from registered state only; data is zero outside STREAM
    always_comb begin
        in_ready  = (r_state == ST_LOAD);
        busy      = (r_state == ST_STREAM) || (r_state == ST_FLUSH);
        out_first = (r_state == ST_STREAM) && (r_t == '0);
        done      = (r_state == ST_FLUSH) && (r_t == T_FLUSH_LAST);
        out_left  = (r_state == ST_STREAM) ? w_left : '0;
        out_top   = (r_state == ST_STREAM) ? w_top  : '0;
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: schedule-based reference model checked every
// cycle, plus literal stream tables and an output-stationary product check.
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int LW = N * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_a_row;
    logic [LW-1:0] in_b_col;
    logic [LW-1:0] out_left;
    logic [LW-1:0] out_top;
    logic          out_first;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    systolic_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a_row  (in_a_row),
        .in_b_col  (in_b_col),
        .out_left  (out_left),
        .out_top   (out_top),
        .out_first (out_first),
        .busy      (busy),
        .done      (done)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: matrices of the last accepted load and the cycle the
    // stream begins; everything else follows from the phase lengths.
    logic [W-1:0]  mA [N][N];
    logic [W-1:0]  mB [N][N];
    int            m_beats = 0;
    bit            m_has   = 1'b0;
    int            m_start = 0;
    int            m_rel;
    bit            m_strm, m_fl;
    logic [LW-1:0] m_el, m_et;
    logic [LW-1:0] rec_left [2*N-1];
    logic [LW-1:0] rec_top  [2*N-1];
    int            first_cyc = 0;
    int            done_cyc  = 0;
    int            done_cnt  = 0;

    always @(negedge clk) begin
        if (reset) begin
            m_beats = 0;
            m_has   = 1'b0;
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_busy", int'(busy), 0);
            chk("rst_first", int'(out_first), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_left", int'(out_left), 0);
            chk("rst_top", int'(out_top), 0);
        end else begin
            m_rel  = m_has ? cyc - m_start : -1;
            m_strm = m_has && m_rel >= 0 && m_rel < 2*N-1;
            m_fl   = m_has && m_rel >= 2*N-1 && m_rel < 3*N-1;
            m_el   = '0;
            m_et   = '0;
            if (m_strm) begin
                for (int i = 0; i < N; i++) begin
                    if (m_rel - i >= 0 && m_rel - i < N) begin
                        m_el[i*W +: W] = mA[i][m_rel-i];
                        m_et[i*W +: W] = mB[m_rel-i][i];
                    end
                end
            end
            chk("in_ready", int'(in_ready), int'(!(m_strm || m_fl)));
            chk("busy", int'(busy), int'(m_strm || m_fl));
            chk("out_first", int'(out_first), int'(m_strm && m_rel == 0));
            chk("done", int'(done), int'(m_fl && m_rel == 3*N-2));
            chk("out_left", int'(out_left), int'(m_el));
            chk("out_top", int'(out_top), int'(m_et));
            if (m_strm) begin
                rec_left[m_rel] = out_left;
                rec_top[m_rel]  = out_top;
            end
            if (out_first) first_cyc = cyc;
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            if (!(m_strm || m_fl) && in_valid) begin
                for (int i = 0; i < N; i++) begin
                    mA[m_beats][i] = in_a_row[i*W +: W];
                    mB[i][m_beats] = in_b_col[i*W +: W];
                end
                m_beats++;
                if (m_beats == N) begin
                    m_beats = 0;
                    m_has   = 1'b1;
                    m_start = cyc + 1;
                end
            end
        end
    end

    // Hand-computed stream tables, lanes packed {lane3,lane2,lane1,lane0}
    logic [LW-1:0] lit_ramp [2*N-1] = '{16'h0001, 16'h0021, 16'h0321, 16'h4321,
                                        16'h4320, 16'h4300, 16'h4000};
    logic [LW-1:0] lit_id   [2*N-1] = '{16'h0001, 16'h0000, 16'h0010, 16'h0000,
                                        16'h0100, 16'h0000, 16'h1000};

    logic [LW-1:0] sa [N];
    logic [LW-1:0] sb [N];
    int            done_before;

    task automatic set_basic();
        for (int k = 0; k < N; k++) begin
            sa[k] = {N{4'(k + 1)}};
            sb[k] = {N{4'(k + 1)}};
        end
    endtask

    task automatic load(input bit gaps);
        done_before = done_cnt;
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_a_row = sa[k];
            in_b_col = sb[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_a_row = '0;
        in_b_col = '0;
        chk("first_after_load", int'(out_first), 1);
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        chk({tag, "_done_seen"}, int'(got), 1);
        @(negedge clk);
        chk({tag, "_ready_after_done"}, int'(in_ready), 1);
        chk({tag, "_done_pulse_once"}, int'(done), 0);
        chk({tag, "_done_count"}, done_cnt - done_before, 1);
        chk({tag, "_done_latency"}, done_cyc - first_cyc, 3*N-2);
        @(posedge clk); #1;
    endtask

    task automatic check_stream(input string tag, input bit ident);
        for (int t = 0; t < 2*N-1; t++) begin
            chk({tag, "_left_lit"}, int'(rec_left[t]), ident ? int'(lit_id[t]) : int'(lit_ramp[t]));
            chk({tag, "_top_lit"}, int'(rec_top[t]), int'(lit_ramp[t]));
        end
    endtask

    // Output-stationary array: PE(i,j) sees left lane i delayed j beats and
    // top lane j delayed i beats; the accumulated sum must equal A x B.
    task automatic check_product();
        logic [LW-1:0] tl, tt;
        int acc;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int t = 0; t < 3*N; t++) begin
                    if (t - j >= 0 && t - j < 2*N-1 && t - i >= 0 && t - i < 2*N-1) begin
                        tl = rec_left[t-j];
                        tt = rec_top[t-i];
                        acc += int'(tl[i*W +: W]) * int'(tt[j*W +: W]);
                    end
                end
                chk($sformatf("product_c%0d%0d", i, j), acc, 4 * (i + 1) * (j + 1));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (%0d checks)", nchk);
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_a_row = '0;
        in_b_col = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_left", int'(out_left), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic load and skewed stream
        set_basic();
        load(1'b0);
        wait_done("basic");
        check_stream("basic", 1'b0);
        check_product();

        // Handshake gaps
        load(1'b1);
        wait_done("gaps");
        check_stream("gaps", 1'b0);

        // Valid held high with junk data while streaming
        load(1'b0);
        in_valid = 1'b1;
        in_a_row = '1;
        in_b_col = '1;
        for (int t = 0; t < 2*N-1; t++) begin
            chk("ready_low_busy", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_a_row = '0;
        in_b_col = '0;
        wait_done("busy_ign");
        check_stream("busy_ign", 1'b0);

        // Back-to-back with identity A
        for (int k = 0; k < N; k++) sa[k] = LW'(1) << (k * W);
        load(1'b0);
        wait_done("ident");
        check_stream("ident", 1'b1);

        // Reset in the middle of the stream
        set_basic();
        load(1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_left", int'(out_left), int'(lit_ramp[3]));
        #2 reset = 1'b1;
        #1;
        chk("async_rst_left", int'(out_left), 0);
        chk("async_rst_top", int'(out_top), 0);
        chk("async_rst_ready", int'(in_ready), 1);
        chk("async_rst_busy", int'(busy), 0);
        done_before = done_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3*N) begin
            @(posedge clk); #1;
        end
        chk("no_done_after_reset", done_cnt - done_before, 0);
        load(1'b0);
        wait_done("post_rst");
        check_stream("post_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
